tse_desc_fetch: RTL
===================

TSE_DESC_FETCH -- requirements
Module: tse_desc_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, descriptor-memory word-address width.
REQ-002 SHALL have parameter TIMEOUT, default 1023, maximum cycles in EXEC before abort.
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  one-cycle pulse: begin walking the chain at first_addr; ignored unless IDLE.
REQ-006 first_addr  in  ADDR_W  word address of the first descriptor.
REQ-007 busy  out  1  high in every state except IDLE.
REQ-008 mem_address  out  ADDR_W; mem_chipselect, mem_write  out  1; mem_byteenable  out  4; mem_writedata  out  32; mem_readdata  in  32: descriptor-memory master port.
REQ-009 desc_valid  out  1; desc_ready  in  1; desc_src, desc_dst  out  32; desc_len  out  16; desc_ctrl  out  7: descriptor to DMA core.
REQ-010 done_valid  in  1; done_status  in  7; done_len  in  16: completion from DMA core.
REQ-011 chain_end  out  1  one-cycle pulse on return to IDLE.

Function
REQ-012 Descriptor layout, 4 words at base B: B+0 src, B+1 dst, B+2 {own[31], ctrl[30:24], rsvd[23:16], len[15:0]}, B+3 next[ADDR_W-1:0].
REQ-013 Memory read latency SHALL be exactly 1: mem_readdata for address presented in cycle N is sampled in cycle N+1.
REQ-014 States: IDLE, FETCH, EVAL, PRESENT, EXEC, WBACK.
REQ-015 IDLE->FETCH on start; base <= first_addr.
REQ-016 FETCH issues B+0..B+3 on consecutive cycles with chipselect=1, write=0; captures words one cycle later; FETCH->EVAL after the fourth capture (5 cycles).
REQ-017 EVAL: own=0 -> IDLE with chain_end; own=1 -> PRESENT.
REQ-018 PRESENT: desc_valid=1, payload held stable until desc_valid&desc_ready; then -> EXEC.
REQ-019 EXEC waits for done_valid; timeout counter counts from 0; reaching TIMEOUT forces status 7'h7F, len 0, -> WBACK.
REQ-020 WBACK: one write cycle to B+2, writedata {1'b0, status, 8'h00, len}, byteenable 4'b1011; own SHALL be cleared.
REQ-021 After WBACK: next==B -> IDLE with chain_end (self-loop guard); else base <= next, -> FETCH.
REQ-022 Address arithmetic SHALL wrap modulo 2^ADDR_W (B=1023 reads 1023,0,1,2).
REQ-023 done_valid outside EXEC SHALL be ignored; done_valid in the timeout cycle SHALL take priority over timeout.
REQ-024 mem_chipselect SHALL be 0 in IDLE, EVAL, PRESENT, EXEC.

Reset
REQ-025 Async reset SHALL force IDLE, busy=0, desc_valid=0, chain_end=0, mem_chipselect=0, mem_write=0, mem_byteenable=0, all captured words and counters to 0.
REQ-026 Reset mid-FETCH or mid-WBACK SHALL abort without further memory access; memory contents are not restored.

Configuration
REQ-027 With TSE_DESC_FETCH_IRQ_EN defined: ports irq (out 1) and irq_clear (in 1); irq sets on chain_end or timeout and stays high until irq_clear (clear wins if same cycle as set); reset clears irq.
REQ-028 Without TSE_DESC_FETCH_IRQ_EN: irq, irq_clear and their register SHALL be absent; all other behaviour identical.

Structure
REQ-029 Shared package tse_desc_pkg SHALL hold the state enum, word offsets (0..3), own bit position 31, byteenable constant 4'b1011, timeout status 7'h7F.
REQ-030 Single flat module; no sub-module.

Verification
REQ-031 One descriptor at 0x010 (own=1, len=0x0040, next=0x010), done_status 0x01/len 0x0040 -> desc_valid with src/dst/len matching; write to 0x012 of 0x01000040 with be=1011; chain_end.
REQ-032 Chain 0x000->0x004->0x008 (own=0 at 0x008) -> two descriptors presented, two writebacks, FETCH at 0x008, chain_end with no third desc_valid.
REQ-033 desc_ready held low 20 cycles -> payload stable throughout, single handshake.
REQ-034 No done_valid, TIMEOUT=15 -> WBACK after 15 EXEC cycles, writedata 0x7F000000; irq=1 when IRQ_EN.
REQ-035 Descriptor at 0x3FF -> reads 0x3FF,0x000,0x001,0x002.
REQ-036 Reset asserted during FETCH cycle 2 -> immediately IDLE, chipselect=0, busy=0; subsequent start fetches normally.

Source files
------------

// File: rtl/tse_desc_pkg.sv
// Shared types and constants for the descriptor-chain fetch engine.
// States, descriptor word offsets, own-bit position and writeback encoding.
package tse_desc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_EVAL    = 3'd2,
        ST_PRESENT = 3'd3,
        ST_EXEC    = 3'd4,
        ST_WBACK   = 3'd5
    } state_t;

    localparam logic [1:0] OFF_SRC  = 2'd0;
    localparam logic [1:0] OFF_DST  = 2'd1;
    localparam logic [1:0] OFF_CTRL = 2'd2;
    localparam logic [1:0] OFF_NEXT = 2'd3;

    localparam int         OWN_BIT   = 31;
    localparam logic [3:0] WB_BE     = 4'b1011;
    localparam logic [6:0] TO_STATUS = 7'h7F;

    // Completion word written back over the control word; own is always cleared.
    function automatic logic [31:0] wb_word(input logic [6:0] status, input logic [15:0] len);
        return {1'b0, status, 8'h00, len};
    endfunction

endpackage

// File: rtl/tse_desc_fetch.sv
// Descriptor-chain walker: fetches 4-word descriptors, hands them to the DMA core,
// writes completion status back. Optional interrupt output under TSE_DESC_FETCH_IRQ_EN.
module tse_desc_fetch
    import tse_desc_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    output logic              desc_valid,
    input  logic              desc_ready,
    output logic [31:0]       desc_src,
    output logic [31:0]       desc_dst,
    output logic [15:0]       desc_len,
    output logic [6:0]        desc_ctrl,
    input  logic              done_valid,
    input  logic [6:0]        done_status,
    input  logic [15:0]       done_len,
    output logic              chain_end
`ifdef TSE_DESC_FETCH_IRQ_EN
    ,
    output logic              irq,
    input  logic              irq_clear
`endif
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] base;
    logic [2:0]        fcnt;
    logic [TW-1:0]     tcnt;
    logic [31:0]       src_q;
    logic [31:0]       dst_q;
    logic              own_q;
    logic [6:0]        ctrl_q;
    logic [15:0]       len_q;
    logic [ADDR_W-1:0] next_q;
    logic [6:0]        wb_status;
    logic [15:0]       wb_len;

    logic fetch_issue;
    logic timeout_hit;
    logic self_loop;
    logic to_idle;

    assign fetch_issue = (state == ST_FETCH) && !fcnt[2];
    assign timeout_hit = (state == ST_EXEC) && !done_valid && (tcnt == TW'(TIMEOUT - 1));
    assign self_loop   = (next_q == base);
    assign to_idle     = (state != ST_IDLE) && (state_nxt == ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (start) state_nxt = ST_FETCH;
            ST_FETCH:   if (fcnt == 3'd4) state_nxt = ST_EVAL;
            ST_EVAL:    state_nxt = own_q ? ST_PRESENT : ST_IDLE;
            ST_PRESENT: if (desc_ready) state_nxt = ST_EXEC;
            ST_EXEC:    if (done_valid || timeout_hit) state_nxt = ST_WBACK;
            ST_WBACK:   state_nxt = self_loop ? ST_IDLE : ST_FETCH;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy           = (state != ST_IDLE);
        desc_valid     = (state == ST_PRESENT);
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_byteenable = 4'b0000;
        mem_writedata  = 32'd0;
        mem_address    = base;
        if (fetch_issue) begin
            mem_chipselect = 1'b1;
            mem_byteenable = 4'b1111;
            mem_address    = base + ADDR_W'(fcnt[1:0]);
        end else if (state == ST_WBACK) begin
            mem_chipselect = 1'b1;
            mem_write      = 1'b1;
            mem_byteenable = WB_BE;
            mem_writedata  = wb_word(wb_status, wb_len);
            mem_address    = base + ADDR_W'(OFF_CTRL);
        end
    end

    assign desc_src  = src_q;
    assign desc_dst  = dst_q;
    assign desc_len  = len_q;
    assign desc_ctrl = ctrl_q;

    // Read data for the word issued at fcnt=k arrives while fcnt=k+1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base      <= '0;
            fcnt      <= '0;
            tcnt      <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            own_q     <= 1'b0;
            ctrl_q    <= '0;
            len_q     <= '0;
            next_q    <= '0;
            wb_status <= '0;
            wb_len    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        base <= first_addr;
                        fcnt <= '0;
                    end
                end
                ST_FETCH: begin
                    fcnt <= fcnt + 3'd1;
                    if (fcnt == 3'(OFF_SRC) + 3'd1) src_q <= mem_readdata;
                    if (fcnt == 3'(OFF_DST) + 3'd1) dst_q <= mem_readdata;
                    if (fcnt == 3'(OFF_CTRL) + 3'd1) begin
                        own_q  <= mem_readdata[OWN_BIT];
                        ctrl_q <= mem_readdata[30:24];
                        len_q  <= mem_readdata[15:0];
                    end
                    if (fcnt == 3'(OFF_NEXT) + 3'd1) next_q <= mem_readdata[ADDR_W-1:0];
                end
                ST_PRESENT: begin
                    tcnt <= '0;
                end
                ST_EXEC: begin
                    tcnt <= tcnt + TW'(1);
                    if (done_valid) begin
                        wb_status <= done_status;
                        wb_len    <= done_len;
                    end else if (timeout_hit) begin
                        wb_status <= TO_STATUS;
                        wb_len    <= 16'd0;
                    end
                end
                ST_WBACK: begin
                    if (!self_loop) begin
                        base <= next_q;
                        fcnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain_end <= 1'b0;
        end else begin
            chain_end <= to_idle;
        end
    end

`ifdef TSE_DESC_FETCH_IRQ_EN
    // Sticky interrupt; an explicit clear beats a coincident set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq <= 1'b0;
        end else if (irq_clear) begin
            irq <= 1'b0;
        end else if (to_idle || timeout_hit) begin
            irq <= 1'b1;
        end
    end
`endif

endmodule
